ps2_keyboard_rx: RTL and testbench

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

---
 rtl/ps2_keyboard_rx_pkg.sv | 41 ++++
 rtl/ps2_scancode_to_hack.sv | 55 +++++
 rtl/ps2_keyboard_rx.sv | 157 +++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver: frame states, scan-code
// prefix bytes and the Hack special keycodes (128..152).
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [7:0] HACK_NEWLINE   = 8'd128;
    localparam logic [7:0] HACK_BACKSPACE = 8'd129;
    localparam logic [7:0] HACK_LEFT      = 8'd130;
    localparam logic [7:0] HACK_UP        = 8'd131;
    localparam logic [7:0] HACK_RIGHT     = 8'd132;
    localparam logic [7:0] HACK_DOWN      = 8'd133;
    localparam logic [7:0] HACK_HOME      = 8'd134;
    localparam logic [7:0] HACK_END       = 8'd135;
    localparam logic [7:0] HACK_PGUP      = 8'd136;
    localparam logic [7:0] HACK_PGDN      = 8'd137;
    localparam logic [7:0] HACK_INSERT    = 8'd138;
    localparam logic [7:0] HACK_DELETE    = 8'd139;
    localparam logic [7:0] HACK_ESC       = 8'd140;
    localparam logic [7:0] HACK_F1        = 8'd141;
    localparam logic [7:0] HACK_F2        = 8'd142;
    localparam logic [7:0] HACK_F3        = 8'd143;
    localparam logic [7:0] HACK_F4        = 8'd144;
    localparam logic [7:0] HACK_F5        = 8'd145;
    localparam logic [7:0] HACK_F6        = 8'd146;
    localparam logic [7:0] HACK_F7        = 8'd147;
    localparam logic [7:0] HACK_F8        = 8'd148;
    localparam logic [7:0] HACK_F9        = 8'd149;
    localparam logic [7:0] HACK_F10       = 8'd150;
    localparam logic [7:0] HACK_F11       = 8'd151;
    localparam logic [7:0] HACK_F12       = 8'd152;

endpackage

// File: rtl/ps2_scancode_to_hack.sv
// Combinational translation of a set-2 scan code (plus E0 extension flag)
// into a Hack keycode; anything without a Hack equivalent yields 0.
module ps2_scancode_to_hack
    import ps2_keyboard_rx_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] scan_byte,
    output logic [7:0] code
);

    always_comb begin
        code = 8'd0;
        if (ext) begin
            case (scan_byte)
                8'h6B:   code = HACK_LEFT;
                8'h75:   code = HACK_UP;
                8'h74:   code = HACK_RIGHT;
                8'h72:   code = HACK_DOWN;
                8'h6C:   code = HACK_HOME;
                8'h69:   code = HACK_END;
                8'h7D:   code = HACK_PGUP;
                8'h7A:   code = HACK_PGDN;
                8'h70:   code = HACK_INSERT;
                8'h71:   code = HACK_DELETE;
                default: code = 8'd0;
            endcase
        end else begin
            case (scan_byte)
                8'h1C: code = 8'd65;  8'h32: code = 8'd66;  8'h21: code = 8'd67;
                8'h23: code = 8'd68;  8'h24: code = 8'd69;  8'h2B: code = 8'd70;
                8'h34: code = 8'd71;  8'h33: code = 8'd72;  8'h43: code = 8'd73;
                8'h3B: code = 8'd74;  8'h42: code = 8'd75;  8'h4B: code = 8'd76;
                8'h3A: code = 8'd77;  8'h31: code = 8'd78;  8'h44: code = 8'd79;
                8'h4D: code = 8'd80;  8'h15: code = 8'd81;  8'h2D: code = 8'd82;
                8'h1B: code = 8'd83;  8'h2C: code = 8'd84;  8'h3C: code = 8'd85;
                8'h2A: code = 8'd86;  8'h1D: code = 8'd87;  8'h22: code = 8'd88;
                8'h35: code = 8'd89;  8'h1A: code = 8'd90;
                8'h45: code = 8'd48;  8'h16: code = 8'd49;  8'h1E: code = 8'd50;
                8'h26: code = 8'd51;  8'h25: code = 8'd52;  8'h2E: code = 8'd53;
                8'h36: code = 8'd54;  8'h3D: code = 8'd55;  8'h3E: code = 8'd56;
                8'h46: code = 8'd57;
                8'h29: code = 8'd32;
                8'h5A: code = HACK_NEWLINE;
                8'h66: code = HACK_BACKSPACE;
                8'h76: code = HACK_ESC;
                8'h05: code = HACK_F1;   8'h06: code = HACK_F2;   8'h04: code = HACK_F3;
                8'h0C: code = HACK_F4;   8'h03: code = HACK_F5;   8'h0B: code = HACK_F6;
                8'h83: code = HACK_F7;   8'h0A: code = HACK_F8;   8'h01: code = HACK_F9;
                8'h09: code = HACK_F10;  8'h78: code = HACK_F11;  8'h07: code = HACK_F12;
                default: code = 8'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, frames
// bytes with parity/stop/timeout checking and tracks the currently held key.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       scancode_strobe,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          ps2_edge;
    logic          ps2_bit;

    frame_state_t  state;
    frame_state_t  state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] idle_timer;
    logic          timeout;
    logic          parity_ok;
    logic          byte_good;
    logic          frame_bad;

    logic          ext;
    logic          brk;
    logic [7:0]    mapped;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples of the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= ~clk_filt;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign ps2_edge  = clk_filt & ~clk_sync[1] & (filt_cnt == FW'(FILTER_LEN - 1));
    assign ps2_bit   = data_sync[1];
    assign parity_ok = ^{shift_reg, parity_bit};
    assign timeout   = (state != ST_IDLE) && !ps2_edge && (idle_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = ST_IDLE;
        end else if (ps2_edge) begin
            case (state)
                ST_IDLE:   if (!ps2_bit) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_good = 1'b0;
        frame_bad = timeout;
        if (ps2_edge) begin
            case (state)
                ST_IDLE: frame_bad = ps2_bit;
                ST_STOP: begin
                    byte_good = ps2_bit && parity_ok;
                    frame_bad = !(ps2_bit && parity_ok);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt         <= '0;
            shift_reg       <= '0;
            parity_bit      <= 1'b0;
            idle_timer      <= '0;
            scancode_strobe <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            scancode_strobe <= byte_good;
            frame_error     <= frame_bad;
            if (state == ST_IDLE || ps2_edge) idle_timer <= '0;
            else                              idle_timer <= idle_timer + TW'(1);
            if (state != ST_DATA || timeout) bit_cnt <= '0;
            else if (ps2_edge)               bit_cnt <= bit_cnt + 3'd1;
            if (ps2_edge && state == ST_DATA)   shift_reg  <= {ps2_bit, shift_reg[7:1]};
            if (ps2_edge && state == ST_PARITY) parity_bit <= ps2_bit;
        end
    end

    ps2_scancode_to_hack u_map (
        .ext       (ext),
        .scan_byte (shift_reg),
        .code      (mapped)
    );

    // shift_reg only moves in DATA, so it still holds the byte while the strobe is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            keycode <= 8'd0;
        end else if (scancode_strobe) begin
            if (shift_reg == PREFIX_EXT) begin
                ext <= 1'b1;
            end else if (shift_reg == PREFIX_BRK) begin
                brk <= 1'b1;
            end else begin
                if (brk) begin
                    if (mapped == keycode) keycode <= 8'd0;
                end else if (mapped != 8'd0) begin
                    keycode <= mapped;
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: PS/2 frames driven bit by bit, compared against a
// table-driven key-state model.
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 25125;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       scancode_strobe;
    logic       frame_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_err = 0;
    int last_fall_cyc = 0;
    int last_strobe_cyc = 0;
    int last_err_cyc = 0;
    logic [7:0] prev_kc = 8'd0;

    logic [7:0] m_kc = 8'd0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] last_make = 8'h1C;
    logic [7:0] make_pool[$];

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] fkey_sc   [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                   8'h09, 8'h78, 8'h07};
    logic [7:0] ext_sc    [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .keycode         (keycode),
        .scancode_strobe (scancode_strobe),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference keymap, searched from the scan-code tables above.
    function automatic logic [7:0] ref_map(input logic e, input logic [7:0] b);
        if (e) begin
            for (int i = 0; i < 10; i++) if (ext_sc[i] == b) return 8'(130 + i);
            return 8'd0;
        end
        for (int i = 0; i < 26; i++) if (letter_sc[i] == b) return 8'(65 + i);
        for (int i = 0; i < 10; i++) if (digit_sc[i] == b) return 8'(48 + i);
        for (int i = 0; i < 12; i++) if (fkey_sc[i] == b) return 8'(141 + i);
        if (b == 8'h29) return 8'd32;
        if (b == 8'h5A) return 8'd128;
        if (b == 8'h66) return 8'd129;
        if (b == 8'h76) return 8'd140;
        return 8'd0;
    endfunction

    task automatic model_apply(input logic [7:0] b);
        logic [7:0] code;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            code = ref_map(m_ext, b);
            if (m_brk) begin
                if (code == m_kc) m_kc = 8'd0;
            end else if (code != 8'd0) m_kc = code;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // bits[0] goes out first; the device changes data while ps2_clk is high.
    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cycles(half);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input int fault);
        return {(fault != 2), (~^b) ^ (fault == 1), b, 1'b0};
    endfunction

    // fault: 0 good, 1 bad parity, 2 stop bit 0, 3 start bit 1 (single clock pulse)
    task automatic tx_byte(input logic [7:0] b, input int half, input int fault);
        int s0;
        int e0;
        s0 = n_strobe;
        e0 = n_err;
        if (fault == 3) send_bits(11'h7FF, 1, half);
        else            send_bits(frame_bits(b, fault), 11, half);
        wait_cycles(8);
        if (fault == 0) model_apply(b);
        check("strobe_count", n_strobe - s0, (fault == 0) ? 1 : 0);
        check("error_count", n_err - e0, (fault == 0) ? 0 : 1);
        check("keycode", keycode, m_kc);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_kc = keycode;
        end else begin
            if (scancode_strobe === 1'b1) begin
                n_strobe++;
                last_strobe_cyc = cyc;
                check("strobe_latency", cyc - last_fall_cyc, 2 + FILTER_LEN);
            end
            if (frame_error === 1'b1) begin
                n_err++;
                last_err_cyc = cyc;
            end
            if (keycode !== prev_kc) begin
                check("keycode_latency", cyc - last_strobe_cyc, 1);
                prev_kc = keycode;
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got %0d cycles expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench timed out");
    end

    initial begin
        int s0;
        int e0;
        logic [7:0] kc_before;
        logic [7:0] b;
        int f;

        foreach (letter_sc[i]) make_pool.push_back(letter_sc[i]);
        foreach (digit_sc[i])  make_pool.push_back(digit_sc[i]);
        foreach (fkey_sc[i])   make_pool.push_back(fkey_sc[i]);
        make_pool.push_back(8'h29);
        make_pool.push_back(8'h5A);
        make_pool.push_back(8'h66);
        make_pool.push_back(8'h76);

        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(2);
        check("reset_keycode", keycode, 8'd0);
        check("reset_strobe", scancode_strobe, 1'b0);
        check("reset_error", frame_error, 1'b0);

        // 12.5 kHz PS/2 clock: 1005 system cycles per half period.
        tx_byte(8'h1C, 1005, 0);
        check("slow_A", keycode, 8'd65);

        tx_byte(8'h32, 20, 0);
        check("make_B", keycode, 8'd66);
        tx_byte(8'hF0, 20, 0);
        tx_byte(8'h1C, 20, 0);
        check("break_other", keycode, 8'd66);

        tx_byte(8'h1C, 20, 1);
        check("bad_parity_kc", keycode, 8'd66);

        s0 = n_strobe;
        tx_byte(8'hE0, 16, 0);
        tx_byte(8'h75, 16, 0);
        check("ext_up", keycode, 8'd131);
        tx_byte(8'hE0, 16, 0);
        tx_byte(8'hF0, 16, 0);
        tx_byte(8'h75, 16, 0);
        check("ext_up_break", keycode, 8'd0);
        check("ext_strobes", n_strobe - s0, 5);

        tx_byte(8'h5A, 18, 0);
        s0 = n_strobe;
        e0 = n_err;
        kc_before = keycode;
        repeat (5) begin
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(30);
        end
        check("glitch_strobes", n_strobe - s0, 0);
        check("glitch_errors", n_err - e0, 0);
        check("glitch_keycode", keycode, kc_before);

        s0 = n_strobe;
        e0 = n_err;
        send_bits(frame_bits(8'h5A, 0), 5, 20);
        wait_cycles(30000);
        check("timeout_errors", n_err - e0, 1);
        check("timeout_latency", last_err_cyc - last_fall_cyc, 2 + FILTER_LEN + TIMEOUT_CYCLES);
        check("timeout_strobes", n_strobe - s0, 0);
        tx_byte(8'h29, 20, 0);
        check("space", keycode, 8'd32);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = make_pool[$urandom_range(0, make_pool.size() - 1)];
                4:          b = 8'hE0;
                5:          b = 8'hF0;
                6:          b = last_make;
                7:          b = ext_sc[$urandom_range(0, 9)];
                default:    b = 8'($urandom_range(0, 255));
            endcase
            f = $urandom_range(0, 11);
            f = (f < 3) ? f + 1 : 0;
            if (b != 8'hE0 && b != 8'hF0) last_make = b;
            tx_byte(b, $urandom_range(12, 25), f);
        end

        tx_byte(8'h24, 15, 0);
        s0 = n_strobe;
        e0 = n_err;
        send_bits(frame_bits(8'h1C, 0), 6, 15);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        m_kc = 8'd0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cycles(50);
        check("midreset_strobes", n_strobe - s0, 0);
        check("midreset_errors", n_err - e0, 0);
        check("midreset_keycode", keycode, 8'd0);
        tx_byte(8'h45, 15, 0);
        check("after_reset_0", keycode, 8'd48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
